fetch_cycle: RTL and testbench

Instruction-fetch stage of the five-stage RISC-V pipeline, directly upstream of the decode stage. Owns the program counter, runs a single-outstanding request/response handshake to instruction memory, and holds one fetched word in a skid buffer. Drives the IF/ID pipeline register (InstrD, PCD, PCPlus4D) with stall, flush and execute-stage branch/jump redirect.

---
 rtl/fetch_cycle_if.sv | 34 +++
 rtl/fetch_cycle.sv | 147 ++++++++++++++
 tb/tb_fetch_cycle.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_cycle_if.sv
// Port bundle of the instruction-fetch stage: hazard controls, execute redirect,
// instruction-memory request/response and the IF/ID register outputs.
interface fetch_cycle_if;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;

  // Handshake: imem_req is a one-cycle strobe with imem_addr valid alongside it.
  // At most one request is outstanding. Memory answers each request with exactly
  // one imem_rvalid pulse carrying imem_rdata, no earlier than the next cycle.
  // There is no back-pressure on the response.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        FetchBusyF;

  modport master (
    input  StallF, StallD, FlushD, PCSrcE, PCTargetE, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, InstrD, PCD, PCPlus4D, ValidD, FetchBusyF
  );

  modport slave (
    output StallF, StallD, FlushD, PCSrcE, PCTargetE, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, InstrD, PCD, PCPlus4D, ValidD, FetchBusyF
  );
endinterface

// File: rtl/fetch_cycle.sv
// Instruction-fetch stage: owns PCF, keeps a single request outstanding to
// instruction memory, parks the returned word in a one-entry buffer and feeds IF/ID.
module fetch_cycle #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clock,
  input  logic          reset,
  fetch_cycle_if.master fif,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic drain;
  logic req;
  logic capture;

  // The buffer empties into IF/ID whenever decode accepts; a new request may be
  // issued in that same cycle since its response cannot land before the next one.
  assign drain   = buf_valid_q && !fif.StallD && !fif.FlushD;
  assign req     = !reset && (state_q == ST_ISSUE) && !fif.StallF && !fif.PCSrcE &&
                   (!buf_valid_q || drain);
  assign capture = (state_q == ST_WAIT) && fif.imem_rvalid && !fif.PCSrcE;

  always_comb begin
    state_d     = state_q;
    pcf_d       = pcf_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;

    if (drain) begin
      buf_valid_d = 1'b0;
    end

    case (state_q)
      ST_ISSUE: begin
        if (req) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fif.imem_rvalid) begin
          state_d = ST_ISSUE;
        end else if (fif.PCSrcE) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        // The stale response retires the outstanding request whatever else happens.
        if (fif.imem_rvalid) begin
          state_d = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_ISSUE;
      end
    endcase

    if (capture) begin
      buf_valid_d = 1'b1;
      buf_instr_d = fif.imem_rdata;
      buf_pc_d    = pcf_q;
      pcf_d       = pcf_q + 32'd4;
    end

    if (fif.PCSrcE) begin
      pcf_d       = fif.PCTargetE;
      buf_valid_d = 1'b0;
    end
  end

  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;

    if (fif.FlushD) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = 32'h0;
      ifid_pc4_d   = 32'h0;
      ifid_valid_d = 1'b0;
    end else if (fif.StallD) begin
      ifid_instr_d = ifid_instr_q;
    end else if (buf_valid_q) begin
      ifid_instr_d = buf_instr_q;
      ifid_pc_d    = buf_pc_q;
      ifid_pc4_d   = buf_pc_q + 32'd4;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = 32'h0;
      ifid_pc4_d   = 32'h0;
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ISSUE;
      pcf_q        <= RESET_PC;
      buf_valid_q  <= 1'b0;
      buf_instr_q  <= NOP_INSTR;
      buf_pc_q     <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      buf_valid_q  <= buf_valid_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign fif.imem_req   = req;
  assign fif.imem_addr  = pcf_q;
  assign fif.InstrD     = ifid_instr_q;
  assign fif.PCD        = ifid_pc_q;
  assign fif.PCPlus4D   = ifid_pc4_q;
  assign fif.ValidD     = ifid_valid_q;
  assign fif.FetchBusyF = (state_q != ST_ISSUE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_fetch_cycle.sv
// Bench for fetch_cycle: directed cycle table, hand-written redirect/wrap/reset
// sequences and a randomized run scored against a transaction-level model.
module tb_fetch_cycle;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [96:0] BUBBLE   = {NOP, 32'h0, 32'h0, 1'b0};

  typedef struct {
    logic        stf;
    logic        std;
    logic        fld;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_busy;
    logic        exp_valid;
    logic [31:0] exp_pcd;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [1:0]  dbg_state;
  fetch_cycle_if fif();

  fetch_cycle #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clock    (clock),
    .reset    (reset),
    .fif      (fif),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard / model state ----------------
  int          n_err;
  int          n_chk;
  int          cyc;
  int          lat;
  bit          mem_busy;
  bit          stale;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic [31:0] fpc;
  logic [95:0] exp_q[$];   // {cycle received, pc, instr}
  bit          prev_std;
  bit          prev_fld;
  logic [96:0] prev_id;
  vec_t        vecs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h0050_0090;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected IF/ID contents after the edge that closed the previous cycle.
  task automatic check_id(input logic [96:0] id_now);
    logic [96:0] exp;
    logic [95:0] e;
    if (prev_fld) begin
      exp = BUBBLE;
    end else if (prev_std) begin
      exp = prev_id;
    end else if (exp_q.size() != 0 && int'(exp_q[0][95:64]) + 1 < cyc) begin
      e   = exp_q.pop_front();
      exp = {e[31:0], e[63:32], e[63:32] + 32'd4, 1'b1};
    end else begin
      exp = BUBBLE;
    end
    chk("ifid", 128'(id_now), 128'(exp));
  endtask

  // ---------------- driver tasks ----------------
  task automatic model_reset();
    mem_busy = 1'b0;
    stale    = 1'b0;
    mem_cnt  = 0;
    exp_q.delete();
    fpc      = RESET_PC;
    prev_fld = 1'b1;
    prev_std = 1'b0;
    prev_id  = BUBBLE;
  endtask

  task automatic apply_reset(input bit ghost);
    @(negedge clock);
    fif.StallF      = 1'b1;
    fif.StallD      = 1'b0;
    fif.FlushD      = 1'b0;
    fif.PCSrcE      = 1'b0;
    fif.PCTargetE   = 32'h0;
    fif.imem_rvalid = 1'b0;
    fif.imem_rdata  = 32'h0;
    reset           = 1'b1;
    #1;
    chk("reset_outputs", 128'({fif.imem_req, fif.FetchBusyF, fif.ValidD, fif.InstrD, fif.PCD, fif.PCPlus4D}),
        128'({1'b0, 1'b0, 1'b0, NOP, 32'h0, 32'h0}));
    chk("reset_pc", 128'(fif.imem_addr), 128'(RESET_PC));
    fif.StallF = 1'b0;
    @(negedge clock);
    #1;
    chk("req_in_reset", 128'(fif.imem_req), 128'(1'b0));
    @(negedge clock);
    reset      = 1'b0;
    fif.StallF = 1'b1;
    if (ghost) begin
      fif.imem_rvalid = 1'b1;
      fif.imem_rdata  = 32'hDEAD_BEEF;
    end
    model_reset();
  endtask

  // One clock cycle: score the last edge, drive this cycle, respond as memory.
  task automatic step(input logic stf, input logic std, input logic fld,
                      input logic pcs, input logic [31:0] tgt);
    logic        resp;
    logic [31:0] word;
    logic [96:0] id_now;
    logic        buf_full;
    logic        exp_req;
    @(negedge clock);
    id_now = {fif.InstrD, fif.PCD, fif.PCPlus4D, fif.ValidD};
    check_id(id_now);
    prev_id       = id_now;
    fif.StallF    = stf;
    fif.StallD    = std;
    fif.FlushD    = fld;
    fif.PCSrcE    = pcs;
    fif.PCTargetE = tgt;
    resp = 1'b0;
    word = $urandom;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        resp = 1'b1;
        word = mem_word(mem_addr);
      end else begin
        mem_cnt--;
      end
    end
    fif.imem_rvalid = resp;
    fif.imem_rdata  = word;
    #1;
    chk("busy", 128'(fif.FetchBusyF), 128'(mem_busy));
    buf_full = (exp_q.size() != 0) && (int'(exp_q[0][95:64]) < cyc);
    exp_req  = !mem_busy && !stf && !pcs && (!buf_full || (!std && !fld));
    chk("req", 128'(fif.imem_req), 128'(exp_req));
    if (fif.imem_req === 1'b1) chk("req_addr", 128'(fif.imem_addr), 128'(fpc));
    if (resp) begin
      mem_busy = 1'b0;
      if (!stale && !pcs) begin
        exp_q.push_back({32'(cyc), mem_addr, word});
        fpc = mem_addr + 32'd4;
      end
      stale = 1'b0;
    end
    if (pcs) begin
      if (mem_busy) stale = 1'b1;
      exp_q.delete();
      fpc = tgt;
    end
    if (fif.imem_req === 1'b1) begin
      mem_busy = 1'b1;
      mem_cnt  = lat;
      mem_addr = fif.imem_addr;
    end
    prev_std = std;
    prev_fld = fld;
    cyc++;
  endtask

  task automatic wait_req(input string name);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      if (fif.imem_req === 1'b1) found = 1'b1;
    end
    chk({name, "_req_seen"}, 128'(found), 128'(1'b1));
  endtask

  task automatic add_vec(input logic stf, input logic std, input logic fld,
                         input logic req, input logic [31:0] addr, input logic busy,
                         input logic valid, input logic [31:0] pcd);
    vec_t v;
    v.stf = stf; v.std = std; v.fld = fld;
    v.exp_req = req; v.exp_addr = addr; v.exp_busy = busy;
    v.exp_valid = valid; v.exp_pcd = pcd;
    vecs.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [96:0] exp_id;
    logic        pcs;
    logic [31:0] tgt;
    int          n;
    n_err = 0;
    n_chk = 0;
    cyc   = 0;
    lat   = 0;
    reset = 1'b1;
    model_reset();
    apply_reset(1'b0);

    // Zero-wait memory from reset: stall, flush+stall and StallF windows.
    //       stf   std   fld   req   addr   busy  valid pcd
    add_vec(1'b0, 1'b0, 1'b0, 1'b1, 32'd0,  1'b0, 1'b0, 32'd0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1, 32'd4,  1'b0, 1'b0, 32'd0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 32'd4,  1'b1, 1'b1, 32'd0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1, 32'd8,  1'b0, 1'b0, 32'd0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 32'd8,  1'b1, 1'b1, 32'd4);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 32'd12, 1'b0, 1'b1, 32'd4);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 32'd12, 1'b0, 1'b1, 32'd4);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 32'd12, 1'b0, 1'b1, 32'd4);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 32'd12, 1'b0, 1'b1, 32'd4);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1, 32'd12, 1'b0, 1'b1, 32'd4);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 32'd12, 1'b1, 1'b1, 32'd8);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1, 32'd16, 1'b0, 1'b0, 32'd0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 32'd16, 1'b1, 1'b1, 32'd12);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1, 32'd20, 1'b0, 1'b0, 32'd0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, 32'd20, 1'b1, 1'b1, 32'd16);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, 32'd24, 1'b0, 1'b0, 32'd0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1, 32'd24, 1'b0, 1'b1, 32'd20);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].stf, vecs[i].std, vecs[i].fld, 1'b0, 32'h0);
      chk($sformatf("vec%0d_req", i), 128'(fif.imem_req), 128'(vecs[i].exp_req));
      chk($sformatf("vec%0d_addr", i), 128'(fif.imem_addr), 128'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_busy", i), 128'(fif.FetchBusyF), 128'(vecs[i].exp_busy));
      exp_id = vecs[i].exp_valid ?
               {mem_word(vecs[i].exp_pcd), vecs[i].exp_pcd, vecs[i].exp_pcd + 32'd4, 1'b1} : BUBBLE;
      chk($sformatf("vec%0d_ifid", i),
          128'({fif.InstrD, fif.PCD, fif.PCPlus4D, fif.ValidD}), 128'(exp_id));
      if (i == 3) chk("first_instr", 128'(fif.InstrD), 128'(32'h0050_0093));
    end

    // Redirect while waiting; the late response must be thrown away.
    lat = 3;
    wait_req("pre_redirect");
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
    chk("redirect_busy", 128'(fif.FetchBusyF), 128'(1'b1));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("drop_busy", 128'(fif.FetchBusyF), 128'(1'b1));
      chk("drop_no_req", 128'(fif.imem_req), 128'(1'b0));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("redirect_req", 128'({fif.imem_req, fif.imem_addr}), 128'({1'b1, 32'h0000_0100}));

    // Response and redirect in the same cycle.
    lat = 0;
    wait_req("pre_simul");
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
    chk("simul_busy", 128'(fif.FetchBusyF), 128'(1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("simul_req", 128'({fif.FetchBusyF, fif.imem_req, fif.imem_addr}),
        128'({1'b0, 1'b1, 32'h0000_0200}));

    // PC wrap at the top of the address space.
    lat = 1;
    wait_req("pre_wrap");
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    wait_req("wrap_top");
    chk("wrap_top_addr", 128'(fif.imem_addr), 128'(32'hFFFF_FFFC));
    wait_req("wrap_next");
    chk("wrap_next_addr", 128'(fif.imem_addr), 128'(32'h0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_ifid", 128'({fif.InstrD, fif.PCD, fif.PCPlus4D, fif.ValidD}),
        128'({mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1'b1}));

    // Reset while a request is outstanding, with a late response after release.
    lat = 5;
    wait_req("pre_reset");
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_reset(1'b1);
    lat = 0;
    wait_req("post_reset");
    chk("post_reset_addr", 128'(fif.imem_addr), 128'(RESET_PC));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_reset_instr", 128'({fif.InstrD, fif.ValidD}), 128'({32'h0050_0093, 1'b1}));

    // Randomized traffic against the transaction-level model.
    for (int i = 0; i < 1500; i++) begin
      pcs = ($urandom_range(0, 99) < 4);
      tgt = ($urandom_range(0, 3) == 0) ? 32'($urandom) : {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      lat = $urandom_range(0, 3);
      step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 25,
           pcs || ($urandom_range(0, 99) < 8), pcs, tgt);
    end

    lat = 0;
    n = 0;
    while ((exp_q.size() != 0 || mem_busy) && n < 50) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      n++;
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("drain_empty", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
